// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: datapath width, NOP encoding, fetch FSM states and the PC step.
package pipeline_pkg;

   localparam int          XLEN      = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam int          PC_STEP   = 4;

   typedef enum logic [1:0] {
      ST_REQ   = 2'd0,
      ST_HOLD  = 2'd1,
      ST_DRAIN = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load a fetched instruction, insert a bubble, or hold the current contents.
module if_id_reg
   import pipeline_pkg::*;
#(
   parameter int          XLEN      = pipeline_pkg::XLEN,
   parameter logic [31:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load_i,
   input  logic            bubble_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [31:0]     instr_i,
   output logic [XLEN-1:0] pc_o,
   output logic [31:0]     instr_o,
   output logic            valid_o
);

   logic [XLEN-1:0] pc_q,    pc_d;
   logic [31:0]     instr_q, instr_d;
   logic            valid_q, valid_d;

   // Bubble takes precedence over load; the PC field is left as-is on a bubble.
   always_comb begin
      pc_d    = pc_q;
      instr_d = instr_q;
      valid_d = valid_q;
      if (bubble_i) begin
         instr_d = NOP_INSTR;
         valid_d = 1'b0;
      end else if (load_i) begin
         pc_d    = pc_i;
         instr_d = instr_i;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q    <= '0;
         instr_q <= NOP_INSTR;
         valid_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
      end
   end

   assign pc_o    = pc_q;
   assign instr_o = instr_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, imem request/ready handshake FSM, one-entry hold buffer, IF/ID register.
module fetch_stage
   import pipeline_pkg::*;
#(
   parameter int              XLEN      = pipeline_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC  = '0,
   parameter logic [31:0]     NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            PCWrite,
   input  logic            IF_ID_Write,
   input  logic            Flush,
   input  logic [XLEN-1:0] BranchTarget,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic [31:0]     imem_rdata,
   input  logic            imem_ready,
   output logic [XLEN-1:0] IF_ID_PC,
   output logic [31:0]     IF_ID_Instr,
   output logic            IF_ID_Valid
);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] req_addr_q, req_addr_d;
   logic [XLEN-1:0] buf_pc_q, buf_pc_d;
   logic [31:0]     buf_instr_q, buf_instr_d;
   logic [XLEN-1:0] pc_inc;

   logic            ifid_load, ifid_bubble;
   logic [XLEN-1:0] ifid_pc;
   logic [31:0]     ifid_instr;

   assign pc_inc = pc_q + XLEN'(PC_STEP);

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      req_addr_d  = req_addr_q;
      buf_pc_d    = buf_pc_q;
      buf_instr_d = buf_instr_q;
      ifid_load   = 1'b0;
      ifid_bubble = 1'b0;
      ifid_pc     = req_addr_q;
      ifid_instr  = imem_rdata;

      unique case (state_q)
         ST_REQ: begin
            if (imem_ready) begin
               if (Flush) begin
                  pc_d        = BranchTarget;
                  req_addr_d  = BranchTarget;
                  ifid_bubble = 1'b1;
               end else if (IF_ID_Write) begin
                  ifid_load = 1'b1;
                  if (PCWrite) begin
                     pc_d       = pc_inc;
                     req_addr_d = pc_inc;
                  end
               end else begin
                  buf_pc_d    = req_addr_q;
                  buf_instr_d = imem_rdata;
                  state_d     = ST_HOLD;
               end
            end else begin
               // The outstanding request must complete at its original address before redirecting.
               if (Flush) begin
                  pc_d        = BranchTarget;
                  ifid_bubble = 1'b1;
                  state_d     = ST_DRAIN;
               end else if (IF_ID_Write) begin
                  ifid_bubble = 1'b1;
               end
            end
         end

         ST_HOLD: begin
            ifid_pc    = buf_pc_q;
            ifid_instr = buf_instr_q;
            if (Flush) begin
               pc_d        = BranchTarget;
               req_addr_d  = BranchTarget;
               ifid_bubble = 1'b1;
               state_d     = ST_REQ;
            end else if (IF_ID_Write) begin
               ifid_load = 1'b1;
               state_d   = ST_REQ;
               if (PCWrite) begin
                  pc_d       = pc_inc;
                  req_addr_d = pc_inc;
               end
            end
         end

         ST_DRAIN: begin
            if (Flush) begin
               pc_d = BranchTarget;
            end
            ifid_bubble = Flush | IF_ID_Write;
            if (imem_ready) begin
               req_addr_d = pc_d;
               state_d    = ST_REQ;
            end
         end

         default: begin
            state_d = ST_REQ;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_REQ;
         pc_q       <= RESET_PC;
         req_addr_q <= RESET_PC;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_addr_q <= req_addr_d;
      end
   end

   // Buffer contents are only meaningful in HOLD, so they carry no reset.
   always_ff @(posedge clk) begin
      buf_pc_q    <= buf_pc_d;
      buf_instr_q <= buf_instr_d;
   end

   assign imem_req  = (state_q != ST_HOLD);
   assign imem_addr = req_addr_q;

   if_id_reg #(
      .XLEN      (XLEN),
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id (
      .clk      (clk),
      .reset    (reset),
      .load_i   (ifid_load),
      .bubble_i (ifid_bubble),
      .pc_i     (ifid_pc),
      .instr_i  (ifid_instr),
      .pc_o     (IF_ID_PC),
      .instr_o  (IF_ID_Instr),
      .valid_o  (IF_ID_Valid)
   );

endmodule
